// File: rtl/reg_file_pkg.sv
// Shared sizing helpers, index type and zero-register constant for the
// multi-port integer register file.
package reg_file_pkg;

    localparam int REG_DATA_WIDTH_POW_DEF = 6;
    localparam int REG_MEM_DEPTH_POW_DEF  = 5;
    localparam int ZERO_REG               = 0;

    typedef logic [REG_MEM_DEPTH_POW_DEF-1:0] reg_idx_t;

    function automatic int reg_data_width(input int pow);
        return 1 << pow;
    endfunction

    function automatic int reg_mem_depth(input int pow);
        return 1 << pow;
    endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Per-register busy scoreboard: alloc sets, writeback clears, and each read
// port sees the busy bit of its source register with write bypass applied.
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int REG_MEM_DEPTH_POW = REG_MEM_DEPTH_POW_DEF,
    parameter int NUM_READ_PORTS    = 2,
    parameter int NUM_WRITE_PORTS   = 1,
    parameter int BYPASS_EN         = 1,
    parameter int ZERO_REG_EN       = 1
) (
    input  logic                                        clk_in,
    input  logic                                        rst_n_in,
    input  logic [NUM_READ_PORTS*REG_MEM_DEPTH_POW-1:0]  rs_in,
    input  logic [NUM_WRITE_PORTS*REG_MEM_DEPTH_POW-1:0] rd_in,
    input  logic [NUM_WRITE_PORTS-1:0]                   write_en,
    input  logic                                         alloc_en,
    input  logic [REG_MEM_DEPTH_POW-1:0]                 alloc_rd,
    output logic [NUM_READ_PORTS-1:0]                    busy_out
);

    localparam int REG_MEM_DEPTH = reg_mem_depth(REG_MEM_DEPTH_POW);
    localparam logic [REG_MEM_DEPTH_POW-1:0] ZERO_IDX = REG_MEM_DEPTH_POW'(ZERO_REG);

    logic [REG_MEM_DEPTH-1:0] busy_reg;
    logic [REG_MEM_DEPTH-1:0] busy_next;
    logic                     alloc_ok;

    assign alloc_ok = alloc_en && !((ZERO_REG_EN != 0) && (alloc_rd == ZERO_IDX));

    // Alloc is applied after the clears so a new producer supersedes a retiring one.
    always_comb begin
        busy_next = busy_reg;
        for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
            if (write_en[w]) begin
                busy_next[rd_in[w*REG_MEM_DEPTH_POW +: REG_MEM_DEPTH_POW]] = 1'b0;
            end
        end
        if (alloc_ok) begin
            busy_next[alloc_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    for (genvar gi = 0; gi < NUM_READ_PORTS; gi++) begin : g_busy_port
        logic [REG_MEM_DEPTH_POW-1:0] rs_idx;
        logic                         wr_hit;
        logic                         busy_bit;

        assign rs_idx = rs_in[gi*REG_MEM_DEPTH_POW +: REG_MEM_DEPTH_POW];

        always_comb begin
            wr_hit = 1'b0;
            for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
                if (write_en[w] && (rd_in[w*REG_MEM_DEPTH_POW +: REG_MEM_DEPTH_POW] == rs_idx)) begin
                    wr_hit = 1'b1;
                end
            end
        end

        always_comb begin
            busy_bit = busy_reg[rs_idx];
            if ((BYPASS_EN != 0) && wr_hit && !(alloc_ok && (alloc_rd == rs_idx))) begin
                busy_bit = 1'b0;
            end
            if ((ZERO_REG_EN != 0) && (rs_idx == ZERO_IDX)) begin
                busy_bit = 1'b0;
            end
        end

        assign busy_out[gi] = busy_bit;
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with hardwired zero register, optional
// write-to-read bypass and a busy scoreboard for hazard detection.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int REG_DATA_WIDTH_POW = REG_DATA_WIDTH_POW_DEF,
    parameter int REG_MEM_DEPTH_POW  = REG_MEM_DEPTH_POW_DEF,
    parameter int NUM_READ_PORTS     = 2,
    parameter int NUM_WRITE_PORTS    = 1,
    parameter int BYPASS_EN          = 1,
    parameter int ZERO_REG_EN        = 1,
    localparam int REG_DATA_WIDTH    = reg_data_width(REG_DATA_WIDTH_POW)
) (
    input  logic                                         clk_in,
    input  logic                                         rst_n_in,
    input  logic [NUM_READ_PORTS*REG_MEM_DEPTH_POW-1:0]  rs_in,
    output logic [NUM_READ_PORTS*REG_DATA_WIDTH-1:0]     reg_data_out,
    output logic [NUM_READ_PORTS-1:0]                    busy_out,
    input  logic [NUM_WRITE_PORTS*REG_MEM_DEPTH_POW-1:0] rd_in,
    input  logic [NUM_WRITE_PORTS*REG_DATA_WIDTH-1:0]    data_write,
    input  logic [NUM_WRITE_PORTS-1:0]                   write_en,
    input  logic                                         alloc_en,
    input  logic [REG_MEM_DEPTH_POW-1:0]                 alloc_rd
);

    localparam int REG_MEM_DEPTH = reg_mem_depth(REG_MEM_DEPTH_POW);
    localparam logic [REG_MEM_DEPTH_POW-1:0] ZERO_IDX = REG_MEM_DEPTH_POW'(ZERO_REG);

    logic [REG_DATA_WIDTH-1:0] mem_flat [REG_MEM_DEPTH];

    // Later write ports overwrite earlier ones, so the highest index wins a collision.
    for (genvar gi = 0; gi < REG_MEM_DEPTH; gi++) begin : g_reg
        localparam bit IS_ZERO = (ZERO_REG_EN != 0) && (gi == ZERO_REG);

        logic                      wr_hit;
        logic [REG_DATA_WIDTH-1:0] wr_data;
        logic [REG_DATA_WIDTH-1:0] data_reg;

        always_comb begin
            wr_hit  = 1'b0;
            wr_data = '0;
            for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
                if (write_en[w] && (rd_in[w*REG_MEM_DEPTH_POW +: REG_MEM_DEPTH_POW] == REG_MEM_DEPTH_POW'(gi))) begin
                    wr_hit  = 1'b1;
                    wr_data = data_write[w*REG_DATA_WIDTH +: REG_DATA_WIDTH];
                end
            end
        end

        always_ff @(posedge clk_in or negedge rst_n_in) begin
            if (!rst_n_in) begin
                data_reg <= '0;
            end else if (wr_hit && !IS_ZERO) begin
                data_reg <= wr_data;
            end
        end

        assign mem_flat[gi] = data_reg;
    end

    for (genvar gi = 0; gi < NUM_READ_PORTS; gi++) begin : g_read
        logic [REG_MEM_DEPTH_POW-1:0] rs_idx;
        logic [REG_DATA_WIDTH-1:0]    rd_data;

        assign rs_idx = rs_in[gi*REG_MEM_DEPTH_POW +: REG_MEM_DEPTH_POW];

        always_comb begin
            rd_data = mem_flat[rs_idx];
            if (BYPASS_EN != 0) begin
                for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
                    if (write_en[w] && (rd_in[w*REG_MEM_DEPTH_POW +: REG_MEM_DEPTH_POW] == rs_idx)) begin
                        rd_data = data_write[w*REG_DATA_WIDTH +: REG_DATA_WIDTH];
                    end
                end
            end
            if ((ZERO_REG_EN != 0) && (rs_idx == ZERO_IDX)) begin
                rd_data = '0;
            end
        end

        assign reg_data_out[gi*REG_DATA_WIDTH +: REG_DATA_WIDTH] = rd_data;
    end

    reg_file_scoreboard #(
        .REG_MEM_DEPTH_POW (REG_MEM_DEPTH_POW),
        .NUM_READ_PORTS    (NUM_READ_PORTS),
        .NUM_WRITE_PORTS   (NUM_WRITE_PORTS),
        .BYPASS_EN         (BYPASS_EN),
        .ZERO_REG_EN       (ZERO_REG_EN)
    ) u_scoreboard (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .rs_in    (rs_in),
        .rd_in    (rd_in),
        .write_en (write_en),
        .alloc_en (alloc_en),
        .alloc_rd (alloc_rd),
        .busy_out (busy_out)
    );

endmodule
